bcd_digit_sequencer: RTL and testbench

- Controller that steps a single BCD digit (0-9) up or down at a programmable dwell rate.
- Drives both the 4-bit BCD code and its decimal one-hot decode (digits 1..9; digit 0 gives all-zero).
- Supports start/stop/hold control, parallel load, and a one-shot mode that halts at the terminal digit.
- Sits between the control/switch inputs and the display or LED bank in the lab datapath.

---
 rtl/bcd_digit_sequencer.sv | 141 ++++++++++++++
 tb/tb_bcd_digit_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_sequencer.sv
// Single BCD digit sequencer: steps 0-9 up/down at a fixed dwell rate, with one-hot decode.
// Optional define BCD_SEQ_BLINK_EN blanks the decode on alternate phases while paused.
module bcd_digit_sequencer #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       mode_up,
  input  logic       one_shot,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] bcd,
  output logic [8:0] dec,
  output logic       busy,
  output logic       done,
  output logic       wrap,
  output logic       err
);

  localparam logic [DWELL_W-1:0] DwellLast = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e               state_q, state_d;
  logic [3:0]           bcd_q, bcd_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic                 tick;
  logic                 terminal;
  logic [8:0]           dec_raw;

  assign terminal = mode_up ? (bcd_q == 4'd9) : (bcd_q == 4'd0);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    tick    = 1'b0;

    if (stop) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            if (load_val <= 4'd9) bcd_d = load_val;
            else                  err_d = 1'b1;
          end
          if (start) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        // A non-held cycle always counts, so resuming from PAUSE counts in the cycle hold drops.
        StRun, StPause: begin
          if (hold) begin
            state_d = StPause;
          end else begin
            state_d = StRun;
            tick    = 1'b1;
          end
        end
        StDone: begin
          if (start) begin
            state_d = StRun;
            bcd_d   = mode_up ? 4'd0 : 4'd9;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (tick) begin
      if (cnt_q == DwellLast) begin
        cnt_d = '0;
        if (terminal && one_shot) begin
          state_d = StDone;
        end else if (terminal) begin
          bcd_d  = mode_up ? 4'd0 : 4'd9;
          wrap_d = 1'b1;
        end else begin
          bcd_d = mode_up ? (bcd_q + 4'd1) : (bcd_q - 4'd1);
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bcd_q   <= 4'd0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    dec_raw = '0;
    for (int k = 1; k <= 9; k++) begin
      dec_raw[k-1] = (bcd_q == 4'(k));
    end
  end

`ifdef BCD_SEQ_BLINK_EN
  logic [DWELL_W-1:0] blink_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_q + 1'b1;
  end

  assign dec = ((state_q == StPause) && blink_q[DWELL_W-1]) ? 9'd0 : dec_raw;
`else
  assign dec = dec_raw;
`endif

  assign bcd  = bcd_q;
  assign busy = (state_q == StRun) || (state_q == StPause);
  assign done = (state_q == StDone);
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed bench for bcd_digit_sequencer: vector table plus hand sequences for multi-cycle cases.
module tb_bcd_digit_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, hold, mode_up, one_shot, load;
  logic [3:0] load_val;
  logic [3:0] bcd;
  logic [8:0] dec;
  logic       busy, done, wrap, err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_digit_sequencer #(.DWELL(4), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .mode_up(mode_up), .one_shot(one_shot), .load(load), .load_val(load_val),
    .bcd(bcd), .dec(dec), .busy(busy), .done(done), .wrap(wrap), .err(err)
  );

  typedef struct {
    logic       start, stop, hold, mode_up, one_shot, load;
    logic [3:0] load_val;
    logic [3:0] bcd;
    logic       busy, done, wrap, err;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [8:0] dec_of(input logic [3:0] b);
    dec_of = (b == 4'd0) ? 9'd0 : (9'd1 << (b - 4'd1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic st, sp, hd, up, os, ld, input logic [3:0] lv);
    start = st; stop = sp; hold = hd; mode_up = up; one_shot = os; load = ld; load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] b,
                         input logic by, dn, wr, er);
    chk({tag, " bcd"}, 32'(bcd), 32'(b));
    chk({tag, " dec"}, 32'(dec), 32'(dec_of(b)));
    chk({tag, " busy"}, 32'(busy), 32'(by));
    chk({tag, " done"}, 32'(done), 32'(dn));
    chk({tag, " wrap"}, 32'(wrap), 32'(wr));
    chk({tag, " err"}, 32'(err), 32'(er));
  endtask

  task automatic set_vec(input int i, input logic st, sp, hd, up, os, ld,
                         input logic [3:0] lv, input logic [3:0] b,
                         input logic by, dn, wr, er);
    vecs[i] = '{st, sp, hd, up, os, ld, lv, b, by, dn, wr, er};
  endtask

  initial begin
    //          st sp hd up os ld  lv     bcd   by dn wr er
    set_vec( 0, 0, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0, 0);
    set_vec( 1, 0, 0, 0, 0, 0, 1, 4'd7,  4'd7, 0, 0, 0, 0);
    set_vec( 2, 0, 0, 0, 0, 0, 1, 4'd12, 4'd7, 0, 0, 0, 1);
    set_vec( 3, 0, 0, 0, 0, 0, 0, 4'd0,  4'd7, 0, 0, 0, 0);
    set_vec( 4, 0, 0, 0, 1, 0, 1, 4'd8,  4'd8, 0, 0, 0, 0);
    set_vec( 5, 1, 0, 0, 1, 0, 0, 4'd0,  4'd8, 1, 0, 0, 0);
    set_vec( 6, 0, 0, 0, 1, 0, 0, 4'd0,  4'd8, 1, 0, 0, 0);
    set_vec( 7, 0, 0, 0, 1, 0, 0, 4'd0,  4'd8, 1, 0, 0, 0);
    set_vec( 8, 0, 0, 0, 1, 0, 0, 4'd0,  4'd8, 1, 0, 0, 0);
    set_vec( 9, 0, 0, 0, 1, 0, 0, 4'd0,  4'd9, 1, 0, 0, 0);
    set_vec(10, 0, 0, 0, 1, 0, 0, 4'd0,  4'd9, 1, 0, 0, 0);
    set_vec(11, 0, 0, 0, 1, 0, 0, 4'd0,  4'd9, 1, 0, 0, 0);
    set_vec(12, 0, 0, 0, 1, 0, 0, 4'd0,  4'd9, 1, 0, 0, 0);
    set_vec(13, 0, 0, 0, 1, 0, 0, 4'd0,  4'd0, 1, 0, 1, 0);
    set_vec(14, 0, 0, 0, 1, 0, 0, 4'd0,  4'd0, 1, 0, 0, 0);
    set_vec(15, 0, 0, 0, 1, 0, 1, 4'd5,  4'd0, 1, 0, 0, 0);
    set_vec(16, 0, 1, 1, 1, 0, 0, 4'd0,  4'd0, 0, 0, 0, 0);

    set_in(0, 0, 0, 0, 0, 0, 4'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'd0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].start, vecs[i].stop, vecs[i].hold, vecs[i].mode_up,
             vecs[i].one_shot, vecs[i].load, vecs[i].load_val);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].busy, vecs[i].done,
              vecs[i].wrap, vecs[i].err);
    end

    // One-shot count down from 2: halts at 0 in DONE without a wrap pulse.
    set_in(0, 0, 0, 0, 0, 1, 4'd2);
    tick();
    chk("os load bcd", 32'(bcd), 32'd2);
    set_in(1, 0, 0, 0, 1, 0, 4'd0);
    tick();
    chk("os start busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      logic [3:0] eb;
      tick();
      eb = (i < 4) ? 4'd2 : (i < 8) ? 4'd1 : 4'd0;
      chk($sformatf("os c%0d bcd", i), 32'(bcd), 32'(eb));
      chk($sformatf("os c%0d wrap", i), 32'(wrap), 32'd0);
      chk($sformatf("os c%0d done", i), 32'(done), 32'(i == 12));
      chk($sformatf("os c%0d busy", i), 32'(busy), 32'(i < 12));
    end
    set_in(1, 0, 0, 0, 1, 0, 4'd0);
    tick();
    chk_all("done restart", 4'd9, 1, 0, 0, 0);
    set_in(0, 1, 0, 0, 0, 0, 4'd0);
    tick();
    chk_all("stop", 4'd9, 0, 0, 0, 0);

    // Hold two cycles into a dwell; step lands two counted cycles after release.
    set_in(0, 0, 0, 1, 0, 1, 4'd3);
    tick();
    set_in(1, 0, 0, 1, 0, 0, 4'd0);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre-hold bcd", 32'(bcd), 32'd3);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold c%0d bcd", i), 32'(bcd), 32'd3);
      chk($sformatf("hold c%0d busy", i), 32'(busy), 32'd1);
    end
    hold = 1'b0;
    tick();
    chk("resume+1 bcd", 32'(bcd), 32'd3);
    tick();
    chk("resume+2 bcd", 32'(bcd), 32'd4);

    // Asynchronous reset mid-dwell, checked before the next clock edge.
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 4'd0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    tick();
    chk_all("post rst", 4'd0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
